i2s_audio_tx: RTL and testbench

- Serializes the core's 16-bit stereo mix (beeper + AY channel sum, unsigned) into a standard I2S stream for the board DAC.
- Sits directly downstream of the ALF core's audio_out_l/audio_out_r outputs.
- Generates BCK/LRCK locally from the 56 MHz system clock, converts unsigned samples to two's complement and supports glitch-free mute.
- Samples are taken once per frame at a fixed point and reported with a strobe.

---
 rtl/i2s_audio_tx_pkg.sv | 45 ++++
 rtl/i2s_audio_tx_bck_gen.sv | 38 +++
 rtl/i2s_audio_tx.sv | 115 +++++++++++
 tb/tb_i2s_audio_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_audio_tx_pkg.sv
// rtl/i2s_audio_tx_pkg.sv - shared constants, types and slot helpers for the I2S transmitter
package i2s_audio_tx_pkg;

  localparam int I2S_FRAME_BITS  = 64;
  localparam int I2S_SLOT_BITS   = 32;
  localparam int I2S_SAMPLE_BITS = 16;

  // Word-select levels as seen by the DAC.
  typedef enum logic {
    LRCK_LEFT  = 1'b0,
    LRCK_RIGHT = 1'b1
  } lrck_e;

  typedef logic [I2S_SAMPLE_BITS-1:0]        sample_t;
  typedef logic [$clog2(I2S_FRAME_BITS)-1:0] bit_idx_t;

  // Offset-binary to two's complement is just an MSB flip; signed input passes through.
  function automatic sample_t to_twos(input sample_t s, input logic is_signed);
    sample_t w;
    w = s;
    if (!is_signed) begin
      w[I2S_SAMPLE_BITS-1] = ~s[I2S_SAMPLE_BITS-1];
    end
    return w;
  endfunction

  // Serial bit for a frame position: one-BCK I2S delay, MSB first, zero padding
  // after the sample in each 32-bit slot.
  function automatic logic slot_bit(input bit_idx_t cnt, input sample_t l, input sample_t r);
    logic [3:0] l_idx;
    logic [3:0] r_idx;
    logic       b;
    l_idx = 4'(bit_idx_t'(I2S_SAMPLE_BITS) - cnt);
    r_idx = 4'(bit_idx_t'(I2S_SLOT_BITS + I2S_SAMPLE_BITS) - cnt);
    b     = 1'b0;
    if (cnt >= bit_idx_t'(1) && cnt <= bit_idx_t'(I2S_SAMPLE_BITS)) begin
      b = l[l_idx];
    end else if (cnt >= bit_idx_t'(I2S_SLOT_BITS + 1) &&
                 cnt <= bit_idx_t'(I2S_SLOT_BITS + I2S_SAMPLE_BITS)) begin
      b = r[r_idx];
    end
    return b;
  endfunction

endpackage

// File: rtl/i2s_audio_tx_bck_gen.sv
// rtl/i2s_audio_tx_bck_gen.sv - bit-clock divider with one-cycle rise/fall enables
module i2s_bck_gen #(
  parameter int BCK_HALF_DIV = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic bck,
  output logic bck_rise,
  output logic bck_fall
);

  logic [7:0] div_cnt;
  logic       wrap;

  assign wrap     = (div_cnt == 8'(BCK_HALF_DIV - 1));
  // Enables flag the cycle whose clock edge flips bck, so downstream
  // registers update together with the edge itself.
  assign bck_rise = wrap & ~bck;
  assign bck_fall = wrap & bck;

  // Half-period counter; bck toggles every time the counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bck     <= 1'b0;
    end else if (!ena) begin
      div_cnt <= '0;
      bck     <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 8'd1;
      if (wrap) begin
        bck <= ~bck;
      end
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - stereo 16-bit I2S serializer with frame latch and mute
module i2s_audio_tx
  import i2s_audio_tx_pkg::*;
#(
  parameter int BCK_HALF_DIV = 9,
  parameter int SIGNED_IN    = 0
) (
  input  logic        CLK,
  input  logic        N_RESET,
  input  logic        ENA,
  input  logic        MUTE,
  input  logic [15:0] L_IN,
  input  logic [15:0] R_IN,
  output logic        I2S_BCK,
  output logic        I2S_LRCK,
  output logic        I2S_DATA,
  output logic        SAMPLE_REQ
);

  logic     bck_rise;
  logic     bck_fall;
  logic     armed;
  logic     fall_evt;
  logic     frame_wrap;
  bit_idx_t bit_cnt;
  bit_idx_t bit_cnt_nxt;
  sample_t  l_lat;
  sample_t  r_lat;
  sample_t  l_cap;
  sample_t  r_cap;

  i2s_bck_gen #(
    .BCK_HALF_DIV(BCK_HALF_DIV)
  ) u_bck_gen (
    .clk     (CLK),
    .rst_n   (N_RESET),
    .ena     (ENA),
    .bck     (I2S_BCK),
    .bck_rise(bck_rise),
    .bck_fall(bck_fall)
  );

  assign bit_cnt_nxt = bit_cnt + bit_idx_t'(1);
  assign frame_wrap  = (bit_cnt == bit_idx_t'(I2S_FRAME_BITS - 1));
  assign fall_evt    = bck_fall & armed;

  // Words offered for capture: converted to two's complement, or forced to zero when muted.
  always_comb begin
    l_cap = to_twos(L_IN, SIGNED_IN != 0);
    r_cap = to_twos(R_IN, SIGNED_IN != 0);
    if (MUTE) begin
      l_cap = '0;
      r_cap = '0;
    end
  end

  // A fall is acted on only after this block has seen the matching rise.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      armed <= 1'b0;
    end else if (!ENA) begin
      armed <= 1'b0;
    end else if (bck_rise) begin
      armed <= 1'b1;
    end else if (fall_evt) begin
      armed <= 1'b0;
    end
  end

  // Frame position advances on every BCK fall; LRCK follows the slot half.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      bit_cnt  <= bit_idx_t'(I2S_FRAME_BITS - 1);
      I2S_LRCK <= LRCK_RIGHT;
    end else if (!ENA) begin
      bit_cnt  <= bit_idx_t'(I2S_FRAME_BITS - 1);
      I2S_LRCK <= LRCK_RIGHT;
    end else if (fall_evt) begin
      bit_cnt  <= bit_cnt_nxt;
      I2S_LRCK <= bit_cnt_nxt[5];
    end
  end

  // Samples are captured once per frame, at the fall that wraps the frame position.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      l_lat <= '0;
      r_lat <= '0;
    end else if (!ENA) begin
      l_lat <= '0;
      r_lat <= '0;
    end else if (fall_evt && frame_wrap) begin
      l_lat <= l_cap;
      r_lat <= r_cap;
    end
  end

  // Serial data and the capture strobe; position 0 always carries a zero,
  // so the word latched on the same edge is never needed yet.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      I2S_DATA   <= 1'b0;
      SAMPLE_REQ <= 1'b0;
    end else if (!ENA) begin
      I2S_DATA   <= 1'b0;
      SAMPLE_REQ <= 1'b0;
    end else begin
      SAMPLE_REQ <= fall_evt & frame_wrap;
      if (fall_evt) begin
        I2S_DATA <= slot_bit(bit_cnt_nxt, l_lat, r_lat);
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - scoreboard bench for i2s_audio_tx, unsigned and signed instances
module tb_i2s_audio_tx;

  localparam int HALF      = 9;
  localparam int BCK_CYC   = 2 * HALF;
  localparam int FRAME_CYC = 128 * HALF;

  logic        CLK;
  logic        N_RESET;
  logic        ENA;
  logic        MUTE;
  logic [15:0] L_IN;
  logic [15:0] R_IN;

  logic bck_u, lrck_u, data_u, req_u;
  logic bck_s, lrck_s, data_s, req_s;
  logic [1:0] bck, lrck, data, req;

  assign bck  = {bck_s, bck_u};
  assign lrck = {lrck_s, lrck_u};
  assign data = {data_s, data_u};
  assign req  = {req_s, req_u};

  i2s_audio_tx #(.BCK_HALF_DIV(HALF), .SIGNED_IN(0)) dut_u (
    .CLK(CLK), .N_RESET(N_RESET), .ENA(ENA), .MUTE(MUTE), .L_IN(L_IN), .R_IN(R_IN),
    .I2S_BCK(bck_u), .I2S_LRCK(lrck_u), .I2S_DATA(data_u), .SAMPLE_REQ(req_u)
  );

  i2s_audio_tx #(.BCK_HALF_DIV(HALF), .SIGNED_IN(1)) dut_s (
    .CLK(CLK), .N_RESET(N_RESET), .ENA(ENA), .MUTE(MUTE), .L_IN(L_IN), .R_IN(R_IN),
    .I2S_BCK(bck_s), .I2S_LRCK(lrck_s), .I2S_DATA(data_s), .SAMPLE_REQ(req_s)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;
  int e     = 0;
  logic [63:0] q_u[$];
  logic [63:0] q_s[$];

  logic [15:0] dl[4] = '{16'h8000, 16'h0000, 16'h8000, 16'hA5C3};
  logic [15:0] dr[4] = '{16'hFFFF, 16'h5A5A, 16'h8000, 16'h1234};

  task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t: got %h want %h", name, k, $time, got, want);
    end
  endtask

  function automatic logic [15:0] conv(input logic [15:0] s, input bit sgn, input logic m);
    if (m) return 16'h0000;
    if (sgn) return s;
    return s + 16'h8000;
  endfunction

  function automatic logic [63:0] frame_of(input logic [15:0] wl, input logic [15:0] wr);
    return {1'b0, wl, 16'h0000, wr, 15'h0000};
  endfunction

  function automatic int model_bitcnt();
    if (e < BCK_CYC) return 63;
    return (e / BCK_CYC - 1) % 64;
  endfunction

  function automatic logic exp_bck();
    return ((e / HALF) % 2) == 1;
  endfunction

  function automatic logic exp_lrck();
    return model_bitcnt() >= 32;
  endfunction

  function automatic logic exp_req();
    return (e >= BCK_CYC) && (e % FRAME_CYC == BCK_CYC);
  endfunction

  // Reference model: active edges since release, expected frames queued at each latch.
  always @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET || !ENA) begin
      e = 0;
      q_u.delete();
      q_s.delete();
    end else begin
      e++;
      if (e % FRAME_CYC == BCK_CYC) begin
        q_u.push_back(frame_of(conv(L_IN, 1'b0, MUTE), conv(R_IN, 1'b0, MUTE)));
        q_s.push_back(frame_of(conv(L_IN, 1'b1, MUTE), conv(R_IN, 1'b1, MUTE)));
      end
    end
  end

  bit          act[2];
  int          ncol[2];
  logic [63:0] col_d[2];
  logic [63:0] col_lr[2];
  logic [1:0]  prev_bck = 2'b00;
  logic [63:0] ef;
  bit          got_exp;

  // Monitor: timing checks each cycle, frame capture on BCK rise, scoreboard pop per frame.
  always @(posedge CLK) begin
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("bck", k, bck[k], exp_bck());
      chk("lrck", k, lrck[k], exp_lrck());
      chk("sample_req", k, req[k], exp_req());
      if (e < BCK_CYC) chk("idle_data", k, data[k], 0);
      if (e == 0) act[k] = 1'b0;
      if (req[k]) begin
        act[k]  = 1'b1;
        ncol[k] = 0;
      end else if (act[k] && bck[k] && !prev_bck[k]) begin
        col_d[k]  = {col_d[k][62:0], data[k]};
        col_lr[k] = {col_lr[k][62:0], lrck[k]};
        ncol[k]++;
        if (ncol[k] == 64) begin
          act[k]  = 1'b0;
          got_exp = 1'b0;
          if (k == 0) begin
            if (q_u.size() > 0) begin ef = q_u.pop_front(); got_exp = 1'b1; end
          end else begin
            if (q_s.size() > 0) begin ef = q_s.pop_front(); got_exp = 1'b1; end
          end
          chk("frame_queue", k, got_exp, 1);
          if (got_exp) begin
            chk("frame_data", k, col_d[k], ef);
            chk("frame_lrck", k, col_lr[k], {32'h0, 32'hFFFF_FFFF});
          end
        end
      end
      prev_bck[k] = bck[k];
    end
  end

  task automatic count_until(input int what, output int n);
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 3000) begin
      @(posedge CLK);
      #3;
      n++;
      case (what)
        0:       hit = bck_u;
        1:       hit = !bck_u;
        default: hit = req_u;
      endcase
    end
  endtask

  task automatic wait_bitcnt(input int b);
    bit hit;
    int n;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < 2000) begin
      @(negedge CLK);
      n++;
      if (e >= BCK_CYC && model_bitcnt() == b) hit = 1'b1;
    end
    chk("wait_bitcnt", 0, hit, 1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_bck"}, 0, bck_u, 0);
    chk({tag, "_lrck"}, 0, lrck_u, 1);
    chk({tag, "_data"}, 0, data_u, 0);
    chk({tag, "_req"}, 0, req_u, 0);
    chk({tag, "_bck"}, 1, bck_s, 0);
    chk({tag, "_lrck"}, 1, lrck_s, 1);
    chk({tag, "_data"}, 1, data_s, 0);
    chk({tag, "_req"}, 1, req_s, 0);
  endtask

  initial begin
    int n;
    int cyc;
    N_RESET = 1'b0;
    ENA     = 1'b1;
    MUTE    = 1'b0;
    L_IN    = 16'h0000;
    R_IN    = 16'h0000;
    repeat (3) @(negedge CLK);
    check_idle("reset");
    N_RESET = 1'b1;

    count_until(0, n);
    chk("first_rise", 0, n, HALF);
    cyc = n;
    count_until(1, n);
    cyc += n;
    chk("first_fall", 0, cyc, BCK_CYC);
    chk("first_req", 0, req_u, 1);
    chk("first_lrck", 0, lrck_u, 0);
    count_until(0, n);
    cyc += n;
    count_until(1, n);
    cyc += n;
    chk("bck_period", 0, cyc - BCK_CYC, BCK_CYC);
    count_until(2, n);
    cyc += n;
    chk("req_period", 0, cyc - BCK_CYC, FRAME_CYC);

    for (int i = 0; i < 4; i++) begin
      wait_bitcnt(5);
      L_IN = dl[i];
      R_IN = dr[i];
      MUTE = 1'b0;
    end

    for (int i = 0; i < 6; i++) begin
      wait_bitcnt(5);
      L_IN = 16'($urandom);
      R_IN = 16'($urandom);
      MUTE = ($urandom_range(3) == 0);
    end

    wait_bitcnt(5);
    L_IN = 16'($urandom);
    R_IN = 16'($urandom);
    MUTE = 1'b0;
    wait_bitcnt(20);
    MUTE = 1'b1;
    wait_bitcnt(40);
    MUTE = 1'b0;
    wait_bitcnt(50);
    L_IN = 16'($urandom);
    R_IN = 16'($urandom);
    MUTE = 1'b1;
    wait_bitcnt(10);
    MUTE = 1'b0;
    L_IN = 16'hFFFF;
    R_IN = 16'h7FFF;

    wait_bitcnt(40);
    N_RESET = 1'b0;
    #1;
    check_idle("async_rst");
    repeat (3) @(negedge CLK);
    N_RESET = 1'b1;
    count_until(2, n);
    chk("req_after_rst", 0, n, BCK_CYC);

    wait_bitcnt(30);
    ENA = 1'b0;
    repeat (100) @(negedge CLK);
    check_idle("ena_low");
    ENA = 1'b1;
    count_until(2, n);
    chk("req_after_ena", 0, n, BCK_CYC);

    for (int i = 0; i < 3; i++) begin
      wait_bitcnt(5);
      L_IN = 16'($urandom);
      R_IN = 16'($urandom);
      MUTE = 1'b0;
    end
    wait_bitcnt(63);
    repeat (20) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
